// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, field widths and a small majority helper.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WDATA    = 3'd3,
    ST_WACK     = 3'd4,
    ST_RDATA    = 3'd5,
    ST_RACK     = 3'd6,
    ST_IGNORE   = 3'd7
  } slave_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// Conditions scl/sda: synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN), then edge and START/STOP detection.
module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  assign scl_rise_o  = scl_c & ~scl_prev_q;
  assign scl_fall_o  = ~scl_c & scl_prev_q;
  assign start_det_o = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det_o  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  assign sda_s_o     = sda_c;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with fixed address; open-drain sda, no clock stretching.
// Optional glitch filter on scl/sda enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_done,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  busy,
  output logic                  addr_hit
);

  slave_state_e          state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_done_q, rx_done_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;
  logic                  addr_hit_q, addr_hit_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  rw_q, rw_d;

  logic                  scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [I2C_BYTE_W-1:0] byte_in;
  logic                  byte_end;
  logic                  addr_match;

  i2c_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_cond (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl),
    .sda_i      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  assign byte_in    = {shift_q[I2C_BYTE_W-2:0], sda_s};
  assign byte_end   = scl_rise && (bit_cnt_q == 3'd7);
  assign addr_match = (byte_in[I2C_BYTE_W-1:1] == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      addr_hit_q <= addr_hit_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
    end
  end

  // In the ACK states sda_oe_q doubles as the slot phase: low = opening fall pending.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: state_d = state_q;
        ST_ADDR:     if (byte_end) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (scl_fall && sda_oe_q) state_d = rw_q ? ST_RDATA : ST_WDATA;
        ST_WDATA:    if (byte_end) state_d = ST_WACK;
        ST_WACK:     if (scl_fall && sda_oe_q) state_d = ST_WDATA;
        ST_RDATA:    if (scl_fall && (bit_cnt_q == 3'd7)) state_d = ST_RACK;
        ST_RACK: begin
          if (scl_rise && sda_s) state_d = ST_IGNORE;
          else if (scl_fall)     state_d = ST_RDATA;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    addr_hit_d = 1'b0;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_end) begin
              if (addr_match) begin
                addr_hit_d = 1'b1;
                busy_d     = 1'b1;
                rw_d       = byte_in[0];
              end else begin
                busy_d = 1'b0;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_d = rw_q;
          end else if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              shift_d   = {tx_data[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
              bit_cnt_d = '0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_end) begin
              rx_data_d = byte_in;
              rx_done_d = 1'b1;
            end
          end
        end
        ST_WACK: begin
          if (scl_fall) sda_oe_d = ~sda_oe_q;
        end
        ST_RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[I2C_BYTE_W-1];
              shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_s) tx_req_d = 1'b1;
            else        busy_d   = 1'b0;
          end else if (scl_fall) begin
            shift_d   = {tx_data[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
            bit_cnt_d = '0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    rx_data  = rx_data_q;
    rx_done  = rx_done_q;
    tx_req   = tx_req_q;
    busy     = busy_q;
    addr_hit = addr_hit_q;
  end

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master, fabric responder and pulse monitors.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_done, tx_req, busy, addr_hit;

  int compared = 0;
  int mismatched = 0;
  int addr_hit_cnt = 0;
  int rx_done_cnt = 0;
  int tx_req_cnt = 0;
  int slave_drive_cnt = 0;
  logic [7:0] tx_bytes [4];
  int tx_idx = 0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy),
    .addr_hit(addr_hit)
  );

  initial forever begin
    @(negedge clk);
    if (addr_hit === 1'b1) addr_hit_cnt++;
    if (rx_done === 1'b1) rx_done_cnt++;
    if (sda === 1'b0 && !m_sda_low) slave_drive_cnt++;
  end

  // Fabric: answers every tx_req with the next queued byte
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_req === 1'b1) begin
      tx_req_cnt++;
      if (tx_idx < 4) begin
        tx_data = tx_bytes[tx_idx];
        tx_idx++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    addr_hit_cnt = 0;
    rx_done_cnt = 0;
    tx_req_cnt = 0;
    slave_drive_cnt = 0;
    tx_idx = 0;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    wait_cyc(Q); m_sda_low = ~b;
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(Q); s = sda;
    wait_cyc(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_cyc(Q); m_sda_low = 1'b0;
      wait_cyc(Q); scl = 1'b1;
    end
    wait_cyc(Q); m_sda_low = 1'b1;
    wait_cyc(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(Q); m_sda_low = 1'b1;
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(Q); m_sda_low = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(5);
    compared++; if (rx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
    compared++; if (rx_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rx_done: got %b expected 0", rx_done); end
    compared++; if (tx_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_req: got %b expected 0", tx_req); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (addr_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_addr_hit: got %b expected 0", addr_hit); end
    compared++; if (sda !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_sda: got %b expected 1", sda); end
    reset = 1'b0;
    wait_cyc(2 * Q);
  endtask

  task automatic test_write();
    logic a0, a1;
    clear_counts();
    bus_start();
    write_byte(8'hA0, a0);
    compared++; if (a0 !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_addr_ack: got %b expected 0", a0); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_busy_mid: got %b expected 1", busy); end
    write_byte(8'h3C, a1);
    compared++; if (a1 !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_data_ack: got %b expected 0", a1); end
    bus_stop();
    compared++; if (rx_done_cnt !== 1) begin mismatched++; $display("[TB] FAIL wr_rx_done_cnt: got %0d expected 1", rx_done_cnt); end
    compared++; if (rx_data !== 8'h3C) begin mismatched++; $display("[TB] FAIL wr_rx_data: got %h expected 3c", rx_data); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_busy_after_stop: got %b expected 0", busy); end
    compared++; if (addr_hit_cnt !== 1) begin mismatched++; $display("[TB] FAIL wr_addr_hit_cnt: got %0d expected 1", addr_hit_cnt); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_counts();
    bus_start();
    write_byte(8'hA2, a0);
    write_byte(8'h3C, a1);
    bus_stop();
    compared++; if (a0 !== 1'b1) begin mismatched++; $display("[TB] FAIL na_addr_ack: got %b expected 1", a0); end
    compared++; if (slave_drive_cnt !== 0) begin mismatched++; $display("[TB] FAIL na_sda_driven: got %0d cycles expected 0", slave_drive_cnt); end
    compared++; if (addr_hit_cnt !== 0) begin mismatched++; $display("[TB] FAIL na_addr_hit_cnt: got %0d expected 0", addr_hit_cnt); end
    compared++; if (rx_done_cnt !== 0) begin mismatched++; $display("[TB] FAIL na_rx_done_cnt: got %0d expected 0", rx_done_cnt); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL na_busy: got %b expected 0", busy); end
  endtask

  task automatic test_read();
    logic       a0;
    logic [7:0] d0, d1;
    clear_counts();
    tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'hEE; tx_bytes[3] = 8'hEE;
    bus_start();
    write_byte(8'hA1, a0);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    slave_drive_cnt = 0;
    wait_cyc(2 * Q);
    compared++; if (a0 !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_addr_ack: got %b expected 0", a0); end
    compared++; if (d0 !== 8'h96) begin mismatched++; $display("[TB] FAIL rd_byte0: got %h expected 96", d0); end
    compared++; if (d1 !== 8'h5A) begin mismatched++; $display("[TB] FAIL rd_byte1: got %h expected 5a", d1); end
    compared++; if (tx_req_cnt !== 2) begin mismatched++; $display("[TB] FAIL rd_tx_req_cnt: got %0d expected 2", tx_req_cnt); end
    compared++; if (slave_drive_cnt !== 0) begin mismatched++; $display("[TB] FAIL rd_release_after_nack: got %0d cycles expected 0", slave_drive_cnt); end
    bus_stop();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_busy: got %b expected 0", busy); end
  endtask

  task automatic test_repeated_start();
    logic       a0, a1, a2;
    logic [7:0] d;
    clear_counts();
    tx_bytes[0] = 8'hF0; tx_bytes[1] = 8'hEE; tx_bytes[2] = 8'hEE; tx_bytes[3] = 8'hEE;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h11, a1);
    bus_start();
    write_byte(8'hA1, a2);
    read_byte(1'b1, d);
    bus_stop();
    compared++; if (rx_data !== 8'h11) begin mismatched++; $display("[TB] FAIL rs_rx_data: got %h expected 11", rx_data); end
    compared++; if (a2 !== 1'b0) begin mismatched++; $display("[TB] FAIL rs_addr2_ack: got %b expected 0", a2); end
    compared++; if (d !== 8'hF0) begin mismatched++; $display("[TB] FAIL rs_rd_byte: got %h expected f0", d); end
    compared++; if (addr_hit_cnt !== 2) begin mismatched++; $display("[TB] FAIL rs_addr_hit_cnt: got %0d expected 2", addr_hit_cnt); end
    compared++; if (tx_req_cnt !== 1) begin mismatched++; $display("[TB] FAIL rs_tx_req_cnt: got %0d expected 1", tx_req_cnt); end
  endtask

  task automatic test_mid_byte_start();
    logic a0, a1, a2, s;
    logic [3:0] part;
    clear_counts();
    part = 4'b1010;
    bus_start();
    write_byte(8'hA0, a0);
    for (int i = 3; i >= 0; i--) clock_bit(part[i], s);
    bus_start();
    write_byte(8'hA0, a1);
    compared++; if (rx_done_cnt !== 0) begin mismatched++; $display("[TB] FAIL mb_no_rx_done: got %0d expected 0", rx_done_cnt); end
    compared++; if (a1 !== 1'b0) begin mismatched++; $display("[TB] FAIL mb_addr_ack: got %b expected 0", a1); end
    write_byte(8'h77, a2);
    bus_stop();
    compared++; if (rx_done_cnt !== 1) begin mismatched++; $display("[TB] FAIL mb_rx_done_cnt: got %0d expected 1", rx_done_cnt); end
    compared++; if (rx_data !== 8'h77) begin mismatched++; $display("[TB] FAIL mb_rx_data: got %h expected 77", rx_data); end
    compared++; if (addr_hit_cnt !== 2) begin mismatched++; $display("[TB] FAIL mb_addr_hit_cnt: got %0d expected 2", addr_hit_cnt); end
  endtask

  task automatic test_mid_reset();
    logic       s, a1;
    logic [7:0] addr;
    clear_counts();
    addr = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(addr[i], s);
    wait_cyc(Q); m_sda_low = 1'b0;
    wait_cyc(2);
    compared++; if (sda !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_ack_driven: got %b expected 0", sda); end
    reset = 1'b1;
    wait_cyc(2);
    compared++; if (sda !== 1'b1) begin mismatched++; $display("[TB] FAIL mr_sda_released: got %b expected 1", sda); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_busy: got %b expected 0", busy); end
    reset = 1'b0;
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(2 * Q); scl = 1'b0;
    write_byte(8'h55, a1);
    bus_stop();
    compared++; if (a1 !== 1'b1) begin mismatched++; $display("[TB] FAIL mr_ignored_ack: got %b expected 1", a1); end
    compared++; if (rx_done_cnt !== 0) begin mismatched++; $display("[TB] FAIL mr_rx_done_cnt: got %0d expected 0", rx_done_cnt); end
  endtask

  // A one-cycle scl pulse before the data byte: filtered build ignores it,
  // plain build shifts in an extra 1 and completes the byte one bit early.
  task automatic test_glitch();
    logic       a0, a1;
    logic [7:0] exp_rx;
    logic       exp_ack;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_rx = 8'h3C; exp_ack = 1'b0;
`else
    exp_rx = 8'h9E; exp_ack = 1'b1;
`endif
    clear_counts();
    bus_start();
    write_byte(8'hA0, a0);
    wait_cyc(Q); scl = 1'b1;
    wait_cyc(1); scl = 1'b0;
    write_byte(8'h3C, a1);
    bus_stop();
    compared++; if (rx_data !== exp_rx) begin mismatched++; $display("[TB] FAIL gl_rx_data: got %h expected %h", rx_data, exp_rx); end
    compared++; if (a1 !== exp_ack) begin mismatched++; $display("[TB] FAIL gl_data_ack: got %b expected %b", a1, exp_ack); end
    compared++; if (rx_done_cnt !== 1) begin mismatched++; $display("[TB] FAIL gl_rx_done_cnt: got %0d expected 1", rx_done_cnt); end
  endtask

  initial begin
    $display("[TB] i2c_slave bench starting");
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_mid_byte_start();
    test_mid_reset();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
